// File: rtl/aes128_iter_ctrl.sv
// -----------------------------------------------------------------------------
// aes128_iter_ctrl
//
// Iterative AES-128 encryption controller. A single round datapath
// (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) is reused for ten
// consecutive cycles. The round key is expanded on the fly and the round
// constant is advanced alongside it, so no key schedule is stored.
//
// Byte order: bits [127:120] hold FIPS-197 byte 0 and bits [7:0] hold byte 15.
// Byte i is at row (i % 4), column (i / 4) of the AES state.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    plaintext/key presented
//   in_ready   out  1    controller can accept a block (FSM in IDLE)
//   plaintext  in   128  input block
//   key        in   128  cipher key
//   out_valid  out  1    ciphertext valid and held stable
//   out_ready  in   1    downstream accepts the ciphertext
//   ciphertext out  128  encrypted block
//   busy       out  1    FSM in RUN or DONE
//   round_idx  out  4    current round (1..10 in RUN, 0 otherwise)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holds valid and its data stable until that edge;
// ready never depends combinationally on valid. in_ready is a decode of the
// registered FSM state only, and out_valid/ciphertext come straight from
// flops, so there is no combinational path from out_ready to in_ready.
//
// The FSM state is observable at the ports: IDLE <=> in_ready,
// DONE <=> out_valid, RUN <=> busy && !out_valid.
// -----------------------------------------------------------------------------
module aes128_iter_ctrl #(
   parameter int NROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic         busy,
   output logic [3:0]   round_idx
);

   // Only AES-128 is implemented; any other round count stops elaboration.
   if (NROUNDS != 10) begin : g_bad_nrounds
      $error("aes128_iter_ctrl: only NROUNDS = 10 is supported");
   end

   localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_e;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[2047 - 8 * int'(x) -: 8];
   endfunction

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // SubBytes and ShiftRows fused: output (row w, col c) takes the
   // substituted input byte from (row w, col (c + w) % 4).
   function automatic logic [127:0] sub_shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) begin
            r[127 - 8 * (4 * c + w) -: 8] =
               sbox(s[127 - 8 * (4 * ((c + w) % 4) + w) -: 8]);
         end
      end
      return r;
   endfunction

   // MixColumns: each output byte is 2*a[w] ^ 3*a[w+1] ^ a[w+2] ^ a[w+3].
   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a [4];
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) begin
            a[w] = s[127 - 8 * (4 * c + w) -: 8];
         end
         for (int w = 0; w < 4; w++) begin
            r[127 - 8 * (4 * c + w) -: 8] =
               xtime(a[w]) ^ xtime(a[(w + 1) % 4]) ^ a[(w + 1) % 4] ^
               a[(w + 2) % 4] ^ a[(w + 3) % 4];
         end
      end
      return r;
   endfunction

   // One step of the AES-128 key schedule: four new words from the
   // previous round key, using RotWord/SubWord on the last word.
   function automatic logic [127:0] key_expand(input logic [127:0] k,
                                               input logic [7:0]   rc);
      logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
      w0 = k[127:96];
      w1 = k[95:64];
      w2 = k[63:32];
      w3 = k[31:0];
      t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]),
            sbox(w3[31:24])};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Registers
   fsm_e         fsm_q,       fsm_d;
   logic [127:0] state_q,     state_d;
   logic [127:0] rkey_q,      rkey_d;
   logic [3:0]   round_q,     round_d;
   logic [7:0]   rcon_q,      rcon_d;
   logic [127:0] ct_q,        ct_d;
   logic         out_valid_q, out_valid_d;

   // Round datapath; key expansion runs in parallel with the state path.
   logic [127:0] rk_next;
   logic [127:0] ss_out;
   logic [127:0] mc_out;
   logic [127:0] round_out;

   always_comb begin
      rk_next   = key_expand(rkey_q, rcon_q);
      ss_out    = sub_shift_rows(state_q);
      mc_out    = mix_columns(ss_out);
      // The final round omits MixColumns.
      round_out = ((round_q == LAST_ROUND) ? ss_out : mc_out) ^ rk_next;
   end

   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      rkey_d      = rkey_q;
      round_d     = round_q;
      rcon_d      = rcon_q;
      ct_d        = ct_q;
      out_valid_d = out_valid_q;

      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               // Initial AddRoundKey is folded into the accept.
               state_d = plaintext ^ key;
               rkey_d  = key;
               round_d = 4'd1;
               rcon_d  = 8'h01;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            state_d = round_out;
            rkey_d  = rk_next;
            rcon_d  = xtime(rcon_q);
            round_d = round_q + 4'd1;
            if (round_q == LAST_ROUND) begin
               ct_d        = round_out;
               out_valid_d = 1'b1;
               round_d     = 4'd0;
               fsm_d       = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               fsm_d       = IDLE;
            end
         end
         default: begin
            fsm_d       = IDLE;
            round_d     = 4'd0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         rkey_q      <= '0;
         round_q     <= '0;
         rcon_q      <= '0;
         ct_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         rkey_q      <= rkey_d;
         round_q     <= round_d;
         rcon_q      <= rcon_d;
         ct_q        <= ct_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready   = (fsm_q == IDLE);
   assign busy       = (fsm_q != IDLE);
   assign out_valid  = out_valid_q;
   assign ciphertext = ct_q;
   assign round_idx  = round_q;

endmodule
